// File: rtl/sha256_padder.sv
// FIPS 180-4 padder feeding 512-bit blocks to sha256 core; last word to core_start in 2 cycles.
// in_ready low from PAD until the core's done; each block held stable until core_done.
module sha256_padder #(
    parameter int unsigned LEN_W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic [2:0]   in_nbytes,
    output logic         core_init,
    output logic         core_start,
    output logic [511:0] core_block,
    input  logic         core_done,
    output logic         busy,
    output logic         msg_done
);

    localparam int unsigned CW = LEN_W - 3;

    typedef enum logic [2:0] {IDLE, FILL, PAD, ISSUE, WAIT} state_t;

    state_t        state_q, state_d;
    logic [31:0]   blk_q [16];
    logic [31:0]   blk_d [16];
    logic [4:0]    w_q, w_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          marker_q, marker_d;
    logic          last_q, last_d;
    logic          final_q, final_d;
    logic          msg_done_q, msg_done_d;

    logic          accept;
    logic [2:0]    nb;
    logic [2:0]    add_bytes;
    logic [31:0]   shaped;
    logic [4:0]    wb;
    logic [CW-1:0] cb;
    logic [4:0]    w_eff;
    logic [63:0]   len;

    assign in_ready   = (state_q == IDLE) || (state_q == FILL);
    assign accept     = in_valid && in_ready;
    assign core_init  = accept && (state_q == IDLE);
    assign core_start = (state_q == ISSUE);
    assign busy       = (state_q != IDLE);
    assign msg_done   = msg_done_q;

    always_comb begin
        core_block = '0;
        for (int i = 0; i < 16; i++) core_block[32*i +: 32] = blk_q[i];
    end

    // Final word: keep the first nb bytes, append the 0x80 marker right after them.
    always_comb begin
        nb        = (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;
        shaped    = in_data;
        add_bytes = 3'd4;
        if (in_last) begin
            add_bytes = nb;
            if (nb != 3'd4) begin
                for (int k = 0; k < 4; k++) begin
                    if (3'(k) == nb)     shaped[31-8*k -: 8] = 8'h80;
                    else if (3'(k) > nb) shaped[31-8*k -: 8] = 8'h00;
                end
            end
        end
    end

    always_comb begin
        len = '0;
        len[LEN_W-1:0] = {cnt_q, 3'b000};
    end

    always_comb begin
        state_d    = state_q;
        blk_d      = blk_q;
        w_d        = w_q;
        cnt_d      = cnt_q;
        marker_d   = marker_q;
        last_d     = last_q;
        final_d    = final_q;
        msg_done_d = 1'b0;
        wb         = (state_q == IDLE) ? 5'd0 : w_q;
        cb         = (state_q == IDLE) ? '0 : cnt_q;
        w_eff      = w_q + {4'd0, marker_q};

        case (state_q)
            IDLE, FILL: begin
                if (accept) begin
                    if (state_q == IDLE) begin
                        blk_d    = '{default: '0};
                        last_d   = 1'b0;
                        marker_d = 1'b0;
                        final_d  = 1'b0;
                    end
                    blk_d[wb[3:0]] = shaped;
                    w_d   = wb + 5'd1;
                    cnt_d = cb + CW'(add_bytes);
                    if (in_last) begin
                        last_d   = 1'b1;
                        marker_d = (nb == 3'd4);
                    end
                    if (wb == 5'd15) begin
                        final_d = 1'b0;
                        state_d = ISSUE;
                    end else if (in_last) begin
                        state_d = PAD;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            PAD: begin
                // Length only fits if words 14..15 are still free after the marker.
                for (int i = 0; i < 16; i++) begin
                    if (marker_q && (5'(i) == w_q)) begin
                        blk_d[i] = 32'h8000_0000;
                    end else if (5'(i) >= w_eff) begin
                        if (w_eff <= 5'd14 && i == 14)      blk_d[i] = len[63:32];
                        else if (w_eff <= 5'd14 && i == 15) blk_d[i] = len[31:0];
                        else                                blk_d[i] = 32'h0;
                    end
                end
                final_d  = (w_eff <= 5'd14);
                marker_d = 1'b0;
                w_d      = w_eff;
                state_d  = ISSUE;
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (core_done) begin
                    if (final_q) begin
                        msg_done_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        blk_d   = '{default: '0};
                        w_d     = 5'd0;
                        state_d = last_q ? PAD : FILL;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            blk_q      <= '{default: '0};
            w_q        <= '0;
            cnt_q      <= '0;
            marker_q   <= 1'b0;
            last_q     <= 1'b0;
            final_q    <= 1'b0;
            msg_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            blk_q      <= blk_d;
            w_q        <= w_d;
            cnt_q      <= cnt_d;
            marker_q   <= marker_d;
            last_q     <= last_d;
            final_q    <= final_d;
            msg_done_q <= msg_done_d;
        end
    end

endmodule

// File: tb/tb_sha256_padder.sv
// Directed bench for sha256_padder with a behavioural stand-in for the compression core.
module tb_sha256_padder;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic [2:0]   in_nbytes;
    logic         core_init;
    logic         core_start;
    logic [511:0] core_block;
    logic         core_done;
    logic         busy;
    logic         msg_done;

    sha256_padder #(.LEN_W(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_nbytes  (in_nbytes),
        .core_init  (core_init),
        .core_start (core_start),
        .core_block (core_block),
        .core_done  (core_done),
        .busy       (busy),
        .msg_done   (msg_done)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int ninit   = 0;
    int nmsg    = 0;
    int init_cyc = 0;
    int msg_cyc  = 0;

    int nstart = 0, ndone = 0, start_cyc = 0, done_cyc = 0;
    int hold_err = 0, restart_err = 0, ready_err = 0;
    int done_delay = 2;
    int abort = 0;
    int acc_cyc = 0;
    logic [511:0] cap[$];
    logic [511:0] hold;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (core_init) begin
            ninit    <= ninit + 1;
            init_cyc <= cyc;
        end
        if (msg_done) begin
            nmsg    <= nmsg + 1;
            msg_cyc <= cyc;
        end
    end

    // Stand-in core: capture block on start, answer with done after done_delay cycles.
    initial begin
        core_done = 0;
        forever begin
            @(negedge clk);
            if (core_start) begin
                cap.push_back(core_block);
                nstart++;
                start_cyc = cyc;
                hold = core_block;
                for (int k = 0; k < done_delay; k++) begin
                    @(negedge clk);
                    if (abort == 0) begin
                        if (core_block !== hold) hold_err++;
                        if (core_start) restart_err++;
                        if (in_ready) ready_err++;
                    end
                end
                core_done = 1;
                done_cyc  = cyc;
                @(negedge clk);
                core_done = 0;
                ndone++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got=stuck required=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] put(input logic [511:0] b, input int i, input logic [31:0] v);
        logic [511:0] r;
        r = b;
        r[32*i +: 32] = v;
        return r;
    endfunction

    function automatic logic [31:0] mw(input int i);
        return 32'h0001_0203 + 32'(i) * 32'h0404_0404;
    endfunction

    // Caller is positioned just after a rising edge; returns just after the accepting edge.
    task automatic send_word(input logic [31:0] d, input logic l, input logic [2:0] nbytes);
        int t;
        t = 0;
        in_valid  = 1;
        in_data   = d;
        in_last   = l;
        in_nbytes = nbytes;
        @(negedge clk);
        while (!in_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("send_rdy", 512'(in_ready), 512'(1));
        @(posedge clk);
        #1;
        acc_cyc  = cyc - 1;
        in_valid = 0;
        in_last  = 0;
    endtask

    task automatic wait_msg(input int n0);
        int t;
        t = 0;
        while (nmsg == n0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("msg_done_seen", 512'(nmsg - n0), 512'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic run_abc(input string tag);
        int s0, m0, i0, a;
        logic [511:0] e;
        s0 = nstart; m0 = nmsg; i0 = ninit;
        send_word(32'h6162_6300, 1, 3'd3);
        a = acc_cyc;
        wait_msg(m0);
        e = '0;
        e = put(e, 0, 32'h6162_6380);
        e = put(e, 15, 32'h0000_0018);
        chk({tag, "_blk"}, cap[s0], e);
        chk({tag, "_nstart"}, 512'(nstart - s0), 512'(1));
        chk({tag, "_latency"}, 512'(start_cyc - a), 512'(2));
        chk({tag, "_init_lead"}, 512'(start_cyc - init_cyc >= 2), 512'(1));
        chk({tag, "_msg_cyc"}, 512'(msg_cyc), 512'(done_cyc + 1));
        chk({tag, "_ninit"}, 512'(ninit - i0), 512'(1));
    endtask

    initial begin
        int s0, m0, i0, h0, r0, q0, d0, t;
        logic [511:0] e1, e2;

        reset = 0; in_valid = 0; in_data = 0; in_last = 0; in_nbytes = 0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 512'(in_ready), 512'(1));
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_core_start", 512'(core_start), 512'(0));
        chk("rst_core_init", 512'(core_init), 512'(0));
        chk("rst_msg_done", 512'(msg_done), 512'(0));
        chk("rst_core_block", core_block, 512'(0));
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1;

        run_abc("abc");

        // Empty message.
        s0 = nstart; m0 = nmsg;
        send_word(32'hDEAD_BEEF, 1, 3'd0);
        wait_msg(m0);
        chk("empty_blk", cap[s0], put(512'(0), 0, 32'h8000_0000));
        chk("empty_nstart", 512'(nstart - s0), 512'(1));

        // One byte, trailing garbage masked off.
        s0 = nstart; m0 = nmsg;
        send_word(32'h41FF_FFFF, 1, 3'd1);
        wait_msg(m0);
        e1 = put(put(512'(0), 0, 32'h4180_0000), 15, 32'h8);
        chk("n1_blk", cap[s0], e1);

        // nbytes ignored on non-last word; nbytes=7 treated as 4.
        s0 = nstart; m0 = nmsg;
        send_word(32'h1122_3344, 0, 3'd2);
        send_word(32'hAABB_CCDD, 1, 3'd7);
        wait_msg(m0);
        e1 = put(put(put(put(512'(0), 0, 32'h1122_3344), 1, 32'hAABB_CCDD), 2, 32'h8000_0000), 15, 32'h40);
        chk("n7_blk", cap[s0], e1);

        // 56 bytes: marker fits, length spills into a second block.
        s0 = nstart; m0 = nmsg;
        for (int i = 0; i < 14; i++) send_word(mw(i), (i == 13), 3'd4);
        wait_msg(m0);
        e1 = '0;
        for (int i = 0; i < 14; i++) e1 = put(e1, i, mw(i));
        e1 = put(e1, 14, 32'h8000_0000);
        chk("b56_blk1", cap[s0], e1);
        chk("b56_blk2", cap[s0+1], put(512'(0), 15, 32'h0000_01C0));
        chk("b56_nstart", 512'(nstart - s0), 512'(2));
        chk("b56_msg_cyc", 512'(msg_cyc), 512'(done_cyc + 1));

        // 64 bytes: full data block, then marker + length block.
        s0 = nstart; m0 = nmsg; r0 = ready_err;
        for (int i = 0; i < 16; i++) send_word(mw(i), (i == 15), 3'd4);
        wait_msg(m0);
        e1 = '0;
        for (int i = 0; i < 16; i++) e1 = put(e1, i, mw(i));
        chk("b64_blk1", cap[s0], e1);
        chk("b64_blk2", cap[s0+1], put(put(512'(0), 0, 32'h8000_0000), 15, 32'h0000_0200));
        chk("b64_ready_low", 512'(ready_err - r0), 512'(0));

        // 68 bytes, slow core, 17th word offered during WAIT.
        done_delay = 100;
        s0 = nstart; m0 = nmsg; i0 = ninit; h0 = hold_err; q0 = restart_err;
        for (int i = 0; i < 16; i++) send_word(mw(i), 0, 3'd4);
        send_word(mw(16), 1, 3'd4);
        chk("slow_accept_cyc", 512'(acc_cyc), 512'(done_cyc + 1));
        wait_msg(m0);
        chk("slow_blk1", cap[s0], e1);
        e2 = put(put(put(512'(0), 0, mw(16)), 1, 32'h8000_0000), 15, 32'h0000_0220);
        chk("slow_blk2", cap[s0+1], e2);
        chk("slow_hold", 512'(hold_err - h0), 512'(0));
        chk("slow_no_restart", 512'(restart_err - q0), 512'(0));
        chk("slow_nstart", 512'(nstart - s0), 512'(2));
        chk("slow_ninit", 512'(ninit - i0), 512'(1));
        done_delay = 2;

        // Back-to-back messages.
        run_abc("b2b_a");
        run_abc("b2b_b");

        // Reset dropped while the core works on block 1.
        done_delay = 20;
        s0 = nstart; d0 = ndone;
        for (int i = 0; i < 16; i++) send_word(mw(i), 0, 3'd4);
        t = 0;
        while (nstart == s0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (5) @(negedge clk);
        #2;
        abort = 1;
        reset = 0;
        #1;
        chk("mid_rst_busy", 512'(busy), 512'(0));
        chk("mid_rst_in_ready", 512'(in_ready), 512'(1));
        chk("mid_rst_block", core_block, 512'(0));
        chk("mid_rst_start", 512'(core_start), 512'(0));
        @(posedge clk); #1 reset = 1;
        t = 0;
        while (ndone == d0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        chk("stray_done_ignored", 512'(busy), 512'(0));
        abort = 0;
        done_delay = 2;
        @(posedge clk); #1;
        run_abc("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
